// File: rtl/dsm_pkg.sv
// Shared constants, types and ratio helpers for the DSM modulus path.
package dsm_pkg;

   localparam int P         = 8;
   localparam int LOG2_P    = $clog2(P);
   localparam int N_WIDTH   = 9;
   localparam int M_WIDTH   = N_WIDTH - LOG2_P;
   localparam int S_WIDTH   = LOG2_P;
   localparam int PRE_WIDTH = LOG2_P + 1;

   typedef logic [N_WIDTH-1:0] ratio_t;
   typedef logic [M_WIDTH-1:0] m_cnt_t;
   typedef logic [S_WIDTH-1:0] s_cnt_t;

   typedef struct packed {
      m_cnt_t m;
      s_cnt_t s;
   } ratio_split_t;

   localparam ratio_t DEFAULT_N = N_WIDTH'(248);

   // N = M*P + S with P a power of two, so the split is a plain bit slice.
   function automatic ratio_split_t split_ratio(input ratio_t n);
      ratio_split_t r;
      r.m = n[N_WIDTH-1:LOG2_P];
      r.s = n[LOG2_P-1:0];
      return r;
   endfunction

   // A ratio is realisable only if at least one prescaler period exists and
   // the swallow count fits inside the program count.
   function automatic logic ratio_legal(input ratio_split_t r);
      return (r.m != '0) && (M_WIDTH'(r.s) <= r.m);
   endfunction

   localparam ratio_split_t DEFAULT_SPLIT = split_ratio(DEFAULT_N);

endpackage

// File: rtl/pulse_swallow_divider_if.sv
// Ratio handshake and divider outputs between the DSM and the divider.
interface pulse_swallow_divider_if;
   import dsm_pkg::*;

   ratio_t ratio_in;
   logic   ratio_valid;
   logic   ratio_ready;
   logic   div_out;
   logic   cycle_end;
   logic   mc;
   logic   err_range;

   // DSM side: offers ratios, observes the divider.
   modport master (
      output ratio_in, ratio_valid,
      input  ratio_ready, div_out, cycle_end, mc, err_range
   );

   // Divider side.
   modport slave (
      input  ratio_in, ratio_valid,
      output ratio_ready, div_out, cycle_end, mc, err_range
   );

endinterface

// File: rtl/dual_mod_prescaler.sv
// P/P+1 prescaler: counts 0..P when mc=1, 0..P-1 when mc=0, and flags the
// terminal count with a one-clk wrap pulse.
module dual_mod_prescaler
   import dsm_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic mc,
   output logic wrap
);

   logic [PRE_WIDTH-1:0] pre_cnt_q, pre_cnt_d;

   // Terminal-count detect and next count.
   always_comb begin
      // NOTE: every output of a combinational block is assigned on every path so no latch is inferred.
      wrap      = mc ? (pre_cnt_q == PRE_WIDTH'(P)) : (pre_cnt_q == PRE_WIDTH'(P - 1));
      pre_cnt_d = wrap ? '0 : pre_cnt_q + PRE_WIDTH'(1);
   end

   // Prescaler count register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
      if (rst) pre_cnt_q <= '0;
      else     pre_cnt_q <= pre_cnt_d;
   end

endmodule

// File: rtl/pulse_swallow_divider.sv
// Pulse-swallow divider: divides clk by the handshaked ratio N using a P/P+1
// prescaler with program (m_cnt) and swallow (s_cnt) counters. A new ratio
// is taken on the last clk of each period and governs the next one.
module pulse_swallow_divider
   import dsm_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   pulse_swallow_divider_if.slave   bus
);

   ratio_t       ratio_q, ratio_d;
   m_cnt_t       m_cnt_q, m_cnt_d;
   s_cnt_t       s_cnt_q, s_cnt_d;
   logic         div_out_q, div_out_d;
   logic         err_range_q, err_range_d;

   logic         mc;
   logic         wrap;
   logic         period_end;
   logic         accept;
   logic         in_legal;
   ratio_split_t in_split;
   ratio_split_t next_split;

   // Swallow phase lasts while swallow periods remain.
   assign mc = (s_cnt_q != '0);

   dual_mod_prescaler u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .mc   (mc),
      .wrap (wrap)
   );

   // Period sequencing, ratio handshake and range check.
   always_comb begin
      in_split    = split_ratio(bus.ratio_in);
      in_legal    = ratio_legal(in_split);
      period_end  = wrap && (m_cnt_q == M_WIDTH'(1));
      accept      = period_end && bus.ratio_valid;
      ratio_d     = ratio_q;
      m_cnt_d     = m_cnt_q;
      s_cnt_d     = s_cnt_q;
      err_range_d = accept && !in_legal;
      if (accept && in_legal) ratio_d = bus.ratio_in;
      next_split  = split_ratio(ratio_d);
      if (period_end) begin
         // Reload on the same edge that ends the period: no idle clk.
         m_cnt_d = next_split.m;
         s_cnt_d = next_split.s;
      end else if (wrap) begin
         m_cnt_d = m_cnt_q - M_WIDTH'(1);
         if (s_cnt_q != '0) s_cnt_d = s_cnt_q - S_WIDTH'(1);
      end
      // Computed from next state so the registered output lines up with m_cnt.
      div_out_d = m_cnt_d > (next_split.m >> 1);
   end

   // State registers; reset loads the default ratio and aborts any period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ratio_q     <= DEFAULT_N;
         m_cnt_q     <= DEFAULT_SPLIT.m;
         s_cnt_q     <= DEFAULT_SPLIT.s;
         div_out_q   <= 1'b0;
         err_range_q <= 1'b0;
      end else begin
         ratio_q     <= ratio_d;
         m_cnt_q     <= m_cnt_d;
         s_cnt_q     <= s_cnt_d;
         div_out_q   <= div_out_d;
         err_range_q <= err_range_d;
      end
   end

   // Output mapping.
   assign bus.ratio_ready = period_end;
   assign bus.cycle_end   = period_end;
   assign bus.mc          = mc;
   assign bus.div_out     = div_out_q;
   assign bus.err_range   = err_range_q;

endmodule
